zbus_intctl: RTL and testbench
==============================

# zbus_intctl

Parametrised interrupt and reset controller for the ZX-bus expansion CPLD, generalising the fixed two-source (W5300/SL811) interrupt/reset register to N_CH peripheral channels. Each channel has a synchronised interrupt input with per-channel level/edge mode, sticky pending, enable mask and a software-controlled reset output. The block also owns the global external-interrupt enable that drives the Z80 INT line. It sits behind the CPU port decoder, which supplies register strobes and a 3-bit register index.

## Interface
Parameters:
- N_CH, 2, number of interrupt/reset channels (1..8)
- INT_LEN, 32, INT pulse length in clk cycles (used only with ZBUS_INT_PULSE_EN)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- reg_addr  in  3  register index, valid with reg_wr/reg_rd
- reg_wr  in  1  single-cycle write strobe
- reg_rd  in  1  read qualifier; rd_data driven regardless
- wr_data  in  8  write data
- rd_data  out  8  read data, combinational from reg_addr
- irq_in  in  N_CH  asynchronous active-high channel interrupt inputs (W5300 int_n inverted by top)
- dev_rst_n  out  N_CH  per-channel peripheral reset, active low
- int_req  out  1  internal OR of enabled pending sources
- int_n  out  1  Z80 INT, active low, registered

## Operation
- Registers (unused bits read 0, writes ignored):
  - 0 STATUS: read = pending[N_CH-1:0]; write 1 clears pending of edge-mode channels; level-mode bits ignore writes.
  - 1 ENABLE: R/W mask, reset 0.
  - 2 MODE: R/W, 1 = rising-edge, 0 = level; reset 0.
  - 3 CTRL: bit0 eintena R/W (reset 0); bit7 int_req RO.
  - 4 RESET: R/W; bit i drives dev_rst_n[i]; reset 0, so all devices are held in reset.
  - 5 RAW: RO synchronised irq_in.
  - 6, 7 read 0.
- Sync: 2-flop synchroniser per channel gives s[i]; a third flop gives s_d[i].
- Level channel: pending[i] = s[i], registered.
- Edge channel: pending[i] is set on s & ~s_d and held until W1C.
- Set wins over a same-cycle clear.
- A MODE change 1->0 makes pending follow level on the next cycle.
- int_req = |(pending & ENABLE), registered.
- Level int mode: int_n = ~(int_req & eintena), registered.
- Writing ENABLE/eintena takes effect on int_req/int_n within 2 cycles.

## Timing
- irq_in edge -> s: 2 clk. -> pending: +1. -> int_req: +1. -> int_n: +1. Total 5 clk worst case from async change.
- reg_wr: register updates at the clk edge with reg_wr=1.
- dev_rst_n changes on that edge with no further latency.
- rd_data: combinational; the decoder samples it during reg_rd.
- Reset: all registers, pending and pulse counter are 0. Outputs: dev_rst_n=0, int_req=0, int_n=1, rd_data reflects zeroed registers.
- Reset asserted mid-pulse ends the pulse immediately (int_n=1).

## Configuration
- ZBUS_INT_PULSE_EN defined: int_n is an INT_LEN-cycle low pulse started on the rising edge of (int_req & eintena).
  - Retrigger requires that term to fall and rise again.
  - A counter of width $clog2(INT_LEN+1) is used.
  - Clearing eintena mid-pulse does not truncate the pulse.
- ZBUS_INT_PULSE_EN undefined: level mode as above; no counter is built.

## Structure
- Package zbus_intctl_pkg:
  - register index localparams (REG_STATUS..REG_RAW)
  - CTRL bit positions
  - the N_CH upper limit
- Sub-module zbus_irq_chan, instantiated per channel:
  - synchroniser, edge detect, mode mux, pending/W1C logic
  - inputs: mode, clr; output: pending
- Top level holds the register file, int_req/int_n and the optional pulse generator.

## Test plan
- Reset: after reset, dev_rst_n=all 0, int_n=1, and STATUS/ENABLE/MODE/CTRL/RESET read 0x00.
- Reset register: write RESET=0x02 (N_CH=2) -> dev_rst_n=2'b10 on the next edge; read back 0x02.
- Level int: ENABLE=0x01, CTRL=0x01, irq_in[0]=1 -> int_n=0 within 5 clk; irq_in[0]=0 -> int_n=1 within 5 clk.
- Edge int: MODE=0x02, ENABLE=0x02, 1-cycle-wide (post-sync) pulse on irq_in[1] -> STATUS=0x02 held. Write STATUS=0x02 -> 0x00. Clear coinciding with a new edge -> stays 0x02.
- Masking: pending set, ENABLE=0 -> CTRL bit7=0, int_n=1. eintena=0 with enabled pending -> CTRL bit7=1, int_n=1.
- ZBUS_INT_PULSE_EN, INT_LEN=32: rising int_req&eintena -> int_n low exactly 32 clk. The source held high gives no second pulse. Reset at cycle 10 of the pulse -> int_n=1 immediately.

Source files
------------

// File: rtl/zbus_intctl_pkg.sv
// Shared register map and field positions for the ZX-bus interrupt/reset controller.
package zbus_intctl_pkg;

    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_ENABLE = 3'd1;
    localparam logic [2:0] REG_MODE   = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam logic [2:0] REG_RESET  = 3'd4;
    localparam logic [2:0] REG_RAW    = 3'd5;

    localparam int CTRL_EINTENA_BIT = 0;
    localparam int CTRL_INTREQ_BIT  = 7;

    localparam int N_CH_MAX = 8;

endpackage

// File: rtl/zbus_irq_chan.sv
// One interrupt channel: input synchroniser, rising-edge detect, level/edge
// mode select and sticky pending with write-1-to-clear (set beats clear).
module zbus_irq_chan
    import zbus_intctl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic irq,
    input  logic mode,
    input  logic clr,
    output logic pending,
    output logic sync
);

    logic [1:0] sync_r;
    logic       s_d_r;
    logic       pending_r;
    logic       pending_next_s;
    logic       rise_s;

    // Two-flop synchroniser plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b00;
            s_d_r  <= 1'b0;
        end else begin
            sync_r <= {sync_r[0], irq};
            s_d_r  <= sync_r[1];
        end
    end

    // Level channels track the input; edge channels latch until cleared.
    always_comb begin
        rise_s         = sync_r[1] & ~s_d_r;
        pending_next_s = pending_r;
        if (!mode) begin
            pending_next_s = sync_r[1];
        end else if (rise_s) begin
            pending_next_s = 1'b1;
        end else if (clr) begin
            pending_next_s = 1'b0;
        end else begin
            pending_next_s = pending_r;
        end
    end

    // Pending state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= 1'b0;
        end else begin
            pending_r <= pending_next_s;
        end
    end

    assign pending = pending_r;
    assign sync    = sync_r[1];

endmodule

// File: rtl/zbus_intctl.sv
// Interrupt and reset controller for N_CH ZX-bus peripherals driving Z80 INT.
// Optional feature macro: ZBUS_INT_PULSE_EN (INT_LEN-cycle INT pulse instead of level).
module zbus_intctl
    import zbus_intctl_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int INT_LEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      reg_addr,
    input  logic            reg_wr,
    input  logic            reg_rd,
    input  logic [7:0]      wr_data,
    output logic [7:0]      rd_data,
    input  logic [N_CH-1:0] irq_in,
    output logic [N_CH-1:0] dev_rst_n,
    output logic            int_req,
    output logic            int_n
);

    logic [N_CH-1:0] enable_r;
    logic [N_CH-1:0] mode_r;
    logic [N_CH-1:0] reset_r;
    logic [N_CH-1:0] pending_s;
    logic [N_CH-1:0] sync_s;
    logic [N_CH-1:0] clr_s;
    logic            eintena_r;
    logic            int_req_r;
    logic            int_n_r;
    logic [7:0]      rd_data_s;
    logic            unused_s;

    // Reads are strobe-free and writes use only the implemented low bits.
    assign unused_s = ^{reg_rd, wr_data, INT_LEN[0]};

    // W1C strobe towards the channels.
    always_comb begin
        clr_s = '0;
        if (reg_wr && (reg_addr == REG_STATUS)) begin
            clr_s = wr_data[N_CH-1:0];
        end else begin
            clr_s = '0;
        end
    end

    // Software-writable register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_r  <= '0;
            mode_r    <= '0;
            reset_r   <= '0;
            eintena_r <= 1'b0;
        end else if (reg_wr) begin
            case (reg_addr)
                REG_ENABLE: enable_r  <= wr_data[N_CH-1:0];
                REG_MODE:   mode_r    <= wr_data[N_CH-1:0];
                REG_CTRL:   eintena_r <= wr_data[CTRL_EINTENA_BIT];
                REG_RESET:  reset_r   <= wr_data[N_CH-1:0];
                default:    enable_r  <= enable_r;
            endcase
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        zbus_irq_chan u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .irq     (irq_in[i]),
            .mode    (mode_r[i]),
            .clr     (clr_s[i]),
            .pending (pending_s[i]),
            .sync    (sync_s[i])
        );
    end

    // Registered OR of enabled pending sources.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_req_r <= 1'b0;
        end else begin
            int_req_r <= |(pending_s & enable_r);
        end
    end

`ifdef ZBUS_INT_PULSE_EN
    localparam int CW = $clog2(INT_LEN + 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic          trig_s;
    logic          trig_d_r;

    // A new pulse starts only on a fresh rise while idle; eintena cannot cut it short.
    always_comb begin
        trig_s     = int_req_r & eintena_r;
        cnt_next_s = cnt_r;
        if (trig_s && !trig_d_r && (cnt_r == CW'(0))) begin
            cnt_next_s = CW'(INT_LEN);
        end else if (cnt_r != CW'(0)) begin
            cnt_next_s = cnt_r - CW'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Pulse counter and INT output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= CW'(0);
            trig_d_r <= 1'b0;
            int_n_r  <= 1'b1;
        end else begin
            cnt_r    <= cnt_next_s;
            trig_d_r <= trig_s;
            int_n_r  <= (cnt_next_s == CW'(0));
        end
    end
`else
    // Level INT output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_n_r <= 1'b1;
        end else begin
            int_n_r <= ~(int_req_r & eintena_r);
        end
    end
`endif

    // Combinational read mux; unimplemented bits and indices read zero.
    always_comb begin
        rd_data_s = 8'h00;
        case (reg_addr)
            REG_STATUS: rd_data_s[N_CH-1:0] = pending_s;
            REG_ENABLE: rd_data_s[N_CH-1:0] = enable_r;
            REG_MODE:   rd_data_s[N_CH-1:0] = mode_r;
            REG_CTRL: begin
                rd_data_s[CTRL_EINTENA_BIT] = eintena_r;
                rd_data_s[CTRL_INTREQ_BIT]  = int_req_r;
            end
            REG_RESET:  rd_data_s[N_CH-1:0] = reset_r;
            REG_RAW:    rd_data_s[N_CH-1:0] = sync_s;
            default:    rd_data_s = 8'h00;
        endcase
    end

    assign rd_data   = rd_data_s;
    assign dev_rst_n = reset_r;
    assign int_req   = int_req_r;
    assign int_n     = int_n_r;

endmodule

// File: tb/tb_zbus_intctl.sv
// Directed plus randomized bench for zbus_intctl (N_CH=2) against a behavioural model.
module tb_zbus_intctl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] reg_addr;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic [1:0] irq_in;
    logic [1:0] dev_rst_n;
    logic       int_req;
    logic       int_n;

    int n_chk  = 0;
    int n_fail = 0;

    zbus_intctl #(.N_CH(2), .INT_LEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reg_addr  (reg_addr),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .irq_in    (irq_in),
        .dev_rst_n (dev_rst_n),
        .int_req   (int_req),
        .int_n     (int_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        reg_addr = a;
        wr_data  = d;
        reg_wr   = 1'b1;
        @(posedge clk);
        #1;
        reg_wr   = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        reg_addr = a;
        reg_rd   = 1'b1;
        #1;
        d        = rd_data;
        reg_rd   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        reg_addr = 3'd0;
        reg_wr   = 1'b0;
        reg_rd   = 1'b0;
        wr_data  = 8'h00;
        irq_in   = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Advance edges until int_n equals val or the budget runs out.
    task automatic wait_int_n(input logic val, input int lim, output int k);
        k = 0;
        while ((k < lim) && (int_n !== val)) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    initial begin
        logic [7:0] d;
        logic [1:0] pend_m, en_m, mode_m, prev_m, nirq;
        logic       eint_m, req_m;
        int         k, n_low;

        // Reset state
        do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_dev_rst_n", {6'b0, dev_rst_n}, 8'h00);
        check("rst_int_n", {7'b0, int_n}, 8'h01);
        check("rst_int_req", {7'b0, int_req}, 8'h00);
        for (int a = 0; a < 8; a++) begin
            reg_addr = 3'(a);
            #1;
            check($sformatf("rst_reg%0d", a), rd_data, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Reset register
        wr(3'd4, 8'h02);
        check("reset_dev_rst_n", {6'b0, dev_rst_n}, 8'h02);
        rd(3'd4, d);
        check("reset_readback", d, 8'h02);
        wr(3'd4, 8'hFF);
        check("reset_dev_all", {6'b0, dev_rst_n}, 8'h03);
        rd(3'd4, d);
        check("reset_upper_ignored", d, 8'h03);

        // Level interrupt on channel 0
        wr(3'd1, 8'h01);
        wr(3'd3, 8'h01);
        @(negedge clk);
        irq_in = 2'b01;
`ifndef ZBUS_INT_PULSE_EN
        wait_int_n(1'b0, 8, k);
        check("lvl_int_n_low", {7'b0, int_n}, 8'h00);
        check("lvl_rise_latency_le5", (k <= 5) ? 8'h01 : 8'h00, 8'h01);
        check("lvl_int_req", {7'b0, int_req}, 8'h01);
        rd(3'd5, d);
        check("raw_ch0", d, 8'h01);
        @(negedge clk);
        irq_in = 2'b00;
        wait_int_n(1'b1, 8, k);
        check("lvl_int_n_high", {7'b0, int_n}, 8'h01);
        check("lvl_fall_latency_le5", (k <= 5) ? 8'h01 : 8'h00, 8'h01);
`else
        repeat (6) @(posedge clk);
        rd(3'd0, d);
        check("lvl_status", d, 8'h01);
        @(negedge clk);
        irq_in = 2'b00;
        repeat (6) @(posedge clk);
`endif
        rd(3'd0, d);
        check("lvl_status_follows", d, 8'h00);

        // Edge interrupt on channel 1
        wr(3'd2, 8'h02);
        wr(3'd1, 8'h02);
        @(negedge clk);
        irq_in = 2'b10;
        @(negedge clk);
        irq_in = 2'b00;
        repeat (6) @(posedge clk);
        rd(3'd0, d);
        check("edge_sticky", d, 8'h02);
        rd(3'd3, d);
        check("edge_ctrl_req", d, 8'h81);
        wr(3'd0, 8'h02);
        rd(3'd0, d);
        check("edge_w1c", d, 8'h00);
        @(negedge clk);
        irq_in = 2'b10;
        repeat (2) @(posedge clk);
        wr(3'd0, 8'h02);
        rd(3'd0, d);
        check("edge_set_beats_clr", d, 8'h02);
        @(negedge clk);
        irq_in = 2'b00;

        // Masking
        wr(3'd1, 8'h00);
        repeat (3) @(posedge clk);
        rd(3'd3, d);
        check("mask_enable_ctrl", d, 8'h01);
        check("mask_enable_int_n", {7'b0, int_n}, 8'h01);
        wr(3'd1, 8'h02);
        wr(3'd3, 8'h00);
        repeat (3) @(posedge clk);
        rd(3'd3, d);
        check("mask_eint_ctrl", d, 8'h80);
        check("mask_eint_int_n", {7'b0, int_n}, 8'h01);

        // Randomized phase against the behavioural model
        do_reset();
        pend_m = 2'b00; en_m = 2'b00; mode_m = 2'b00; prev_m = 2'b00; eint_m = 1'b0;
        for (int it = 0; it < 60; it++) begin
            d = 8'($urandom);
            case ($urandom_range(0, 4))
                0: begin
                    nirq = 2'($urandom);
                    @(negedge clk);
                    irq_in = nirq;
                    repeat (6) @(posedge clk);
                    for (int i = 0; i < 2; i++) begin
                        if (mode_m[i]) pend_m[i] = pend_m[i] | (nirq[i] & ~prev_m[i]);
                        else           pend_m[i] = nirq[i];
                    end
                    prev_m = nirq;
                end
                1: begin
                    wr(3'd0, d);
                    pend_m = pend_m & ~(d[1:0] & mode_m);
                end
                2: begin
                    wr(3'd2, d);
                    for (int i = 0; i < 2; i++)
                        if (!d[i]) pend_m[i] = prev_m[i];
                    mode_m = d[1:0];
                end
                3: begin
                    if (d[7]) begin
                        wr(3'd3, d);
                        eint_m = d[0];
                    end else begin
                        wr(3'd1, d);
                        en_m = d[1:0];
                    end
                end
                default: begin
                    wr(3'd4, d);
                    check("rnd_dev_rst_n", {6'b0, dev_rst_n}, {6'b0, d[1:0]});
                end
            endcase
            repeat (3) @(posedge clk);
            req_m = |(pend_m & en_m);
            rd(3'd0, d);
            check("rnd_status", d, {6'b0, pend_m});
            rd(3'd3, d);
            check("rnd_ctrl", d, {req_m, 6'b0, eint_m});
`ifndef ZBUS_INT_PULSE_EN
            check("rnd_int_n", {7'b0, int_n}, {7'b0, ~(req_m & eint_m)});
`endif
        end

`ifdef ZBUS_INT_PULSE_EN
        // Pulse mode: exact length, no retrigger while held, async reset mid-pulse
        do_reset();
        wr(3'd1, 8'h01);
        wr(3'd3, 8'h01);
        @(negedge clk);
        irq_in = 2'b01;
        wait_int_n(1'b0, 10, k);
        check("pulse_start", {7'b0, int_n}, 8'h00);
        n_low = 0;
        while ((int_n === 1'b0) && (n_low < 100)) begin
            @(posedge clk);
            #1;
            n_low++;
        end
        check("pulse_len", 8'(n_low), 8'd32);
        n_low = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (int_n === 1'b0) n_low++;
        end
        check("pulse_no_retrig", 8'(n_low), 8'd0);
        @(negedge clk);
        irq_in = 2'b00;
        repeat (8) @(posedge clk);
        @(negedge clk);
        irq_in = 2'b01;
        wait_int_n(1'b0, 10, k);
        check("pulse_second", {7'b0, int_n}, 8'h00);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("pulse_reset_cut", {7'b0, int_n}, 8'h01);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
